// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds immediate-format selectors, FSM state encoding and a sign-extension helper.
package inst_encoder_pkg;

    localparam logic [2:0] IMMSEL_U = 3'b000;
    localparam logic [2:0] IMMSEL_J = 3'b001;
    localparam logic [2:0] IMMSEL_I = 3'b010;
    localparam logic [2:0] IMMSEL_B = 3'b011;
    localparam logic [2:0] IMMSEL_S = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when bits [31:msb] of v are all equal, i.e. v is a valid
    // sign extension of its low msb+1 bits.
    function automatic logic is_sext(input logic [31:0] v, input int msb);
        logic all1;
        logic all0;
        all1 = 1'b1;
        all0 = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k >= msb) begin
                all1 = all1 & v[k];
                all0 = all0 & ~v[k];
            end
        end
        return all1 | all0;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: decoded fields + immediate -> 32-bit RV32I word.
// Optional range checker compiled in with IMM_RANGE_CHECK_EN.
module imm_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  i_immsel,
    input  logic [31:0] i_imm,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [6:0]  i_funct7,
    output logic [31:0] o_word,
    output logic        o_range_err
);

    logic [31:0] w_m;
    assign w_m = i_imm;

    // Scatter immediate bits into the format-specific word layout
    always_comb begin
        o_word = '0;
        case (i_immsel)
            IMMSEL_U: o_word = {w_m[31:12], i_rd, i_opcode};
            IMMSEL_J: o_word = {w_m[19], w_m[9:0], w_m[10], w_m[18:11],
                                i_rd, i_opcode};
            IMMSEL_I: o_word = {w_m[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            IMMSEL_B: o_word = {w_m[11], w_m[9:4], i_rs2, i_rs1, i_funct3,
                                w_m[3:0], w_m[10], i_opcode};
            IMMSEL_S: o_word = {w_m[11:5], i_rs2, i_rs1, i_funct3,
                                w_m[4:0], i_opcode};
            default:  o_word = {i_funct7, i_rs2, i_rs1, i_funct3,
                                i_rd, i_opcode};
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Flag immediates that would be truncated by the chosen format
    always_comb begin
        o_range_err = 1'b0;
        case (i_immsel)
            IMMSEL_U: o_range_err = (w_m[11:0] != 12'h000);
            IMMSEL_J: o_range_err = ~is_sext(w_m, 19);
            IMMSEL_I,
            IMMSEL_B,
            IMMSEL_S: o_range_err = ~is_sext(w_m, 11);
            default:  o_range_err = 1'b0;
        endcase
    end
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Streams packed RV32I words into instruction memory at consecutive addresses.
// Optional immediate range checking: define IMM_RANGE_CHECK_EN.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int              ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_immsel,
    input  logic [31:0]       in_imm,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] word_cnt,
    output logic              err_ovf,
    output logic              err_range
);

    localparam int CNT_W = ADDR_W - 1;
    localparam logic [CNT_W-1:0] LAST_SLOT =
        CNT_W'((1 << (ADDR_W - 2)) - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_last_slot;
    logic [31:0]       w_word;
    logic              w_range_err;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err_ovf;

    assign w_accept    = in_valid & in_ready;
    assign w_start_ok  = start & (r_state != ST_RUN);
    assign w_last_slot = (r_cnt == LAST_SLOT);

    imm_pack u_pack (
        .i_immsel    (in_immsel),
        .i_imm       (in_imm),
        .i_opcode    (in_opcode),
        .i_rd        (in_rd),
        .i_funct3    (in_funct3),
        .i_rs1       (in_rs1),
        .i_rs2       (in_rs2),
        .i_funct7    (in_funct7),
        .o_word      (w_word),
        .o_range_err (w_range_err)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state: session ends on the final beat or when memory is full
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE,
            ST_DONE: if (start) w_next_state = ST_RUN;
            ST_RUN:  if (w_accept && (in_last || w_last_slot))
                         w_next_state = ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs; ready depends on state only
    always_comb begin
        in_ready = (r_state == ST_RUN);
        busy     = (r_state == ST_RUN);
        done     = (r_state == ST_DONE);
    end

    // Write port register, address/count tracking and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_next_addr <= BASE_ADDR;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr      <= r_next_addr;
                r_wdata     <= w_word;
                r_next_addr <= r_next_addr + ADDR_W'(4);
                r_cnt       <= r_cnt + 1'b1;
                if (w_last_slot && !in_last)
                    r_err_ovf <= 1'b1;
            end else if (w_start_ok) begin
                r_next_addr <= BASE_ADDR;
                r_cnt       <= '0;
                r_err_ovf   <= 1'b0;
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    logic r_err_range;

    // Sticky range error, cleared when a new session starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_range <= 1'b0;
        else if (w_start_ok)
            r_err_range <= 1'b0;
        else if (w_accept && w_range_err)
            r_err_range <= 1'b1;
    end

    assign err_range = r_err_range;
`else
    logic w_unused_range;
    assign w_unused_range = w_range_err;
    assign err_range      = 1'b0;
`endif

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign word_cnt   = r_cnt;
    assign err_ovf    = r_err_ovf;

endmodule
